hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations E..W, drives forward selects, load-use stalls and branch flushes.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_scoreboard #(
  parameter int AW       = 4,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SELW     = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_d,
  input  logic [NUM_SRC*AW-1:0]     ra_d,
  input  logic [AW-1:0]             rd_d,
  input  logic                      we_d,
  input  logic                      load_d,
  input  logic                      branch_taken_e,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  logic              slot_vld_q  [DEPTH];
  logic              slot_vld_d  [DEPTH];
  logic              slot_we_q   [DEPTH];
  logic              slot_we_d   [DEPTH];
  logic              slot_load_q [DEPTH];
  logic              slot_load_d [DEPTH];
  logic [AW-1:0]     slot_rd_q   [DEPTH];
  logic [AW-1:0]     slot_rd_d   [DEPTH];
  logic [NUM_SRC*AW-1:0] ra_e_q;
  logic [NUM_SRC*AW-1:0] ra_e_d;

  logic luse;
  logic branch;

  // A load in slot j reaches slot j+1 when the D reader enters E; stall if still too young to forward.
  always_comb begin
    luse = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j + 1 < LOAD_LAT) && slot_vld_q[j] && slot_we_q[j] && slot_load_q[j] &&
            (slot_rd_q[j] == ra_d[s*AW +: AW])) begin
          luse = 1'b1;
        end
      end
    end
    luse   = luse & valid_d & ~reset;
    branch = branch_taken_e & ~reset;
  end

  // Branch outranks load-use: the stalled D instruction is flushed anyway.
  always_comb begin
    flush_d = branch;
    flush_e = branch | luse;
    stall_f = luse & ~branch;
    stall_d = luse & ~branch;
  end

  // Descending scan so the youngest matching writer (lowest slot) overwrites older ones.
  always_comb begin
    fwd_sel_e = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (slot_vld_q[k] && slot_we_q[k] && (slot_rd_q[k] == ra_e_q[s*AW +: AW])) begin
          fwd_sel_e[s*SELW +: SELW] = SELW'(k);
        end
      end
    end
    if (!slot_vld_q[0] || reset) begin
      fwd_sel_e = '0;
    end
  end

  // Stage boundary: D -> slot0, slot[i-1] -> slot[i]; never frozen, stalls inject bubbles.
  always_comb begin
    slot_vld_d[0]  = valid_d & ~flush_e & ~reset;
    slot_we_d[0]   = we_d;
    slot_load_d[0] = load_d;
    slot_rd_d[0]   = rd_d;
    ra_e_d         = ra_d;
    for (int i = 1; i < DEPTH; i++) begin
      slot_vld_d[i]  = slot_vld_q[i-1] & ~reset;
      slot_we_d[i]   = slot_we_q[i-1];
      slot_load_d[i] = slot_load_q[i-1];
      slot_rd_d[i]   = slot_rd_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld_q[i] <= slot_vld_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_we_q[i]   <= slot_we_d[i];
      slot_load_q[i] <= slot_load_d[i];
      slot_rd_q[i]   <= slot_rd_d[i];
    end
    ra_e_q <= ra_e_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_d && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = reset ? 32'd0 : stall_cnt_q;
  assign flush_cnt = reset ? 32'd0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default parameters): forwarding, load-use, branch priority, reset.
module tb_hazard_scoreboard;

  localparam int AW = 4;
  localparam int NUM_SRC = 2;
  localparam int SELW = 2;

  logic                     clk;
  logic                     reset;
  logic                     valid_d;
  logic [NUM_SRC*AW-1:0]    ra_d;
  logic [AW-1:0]            rd_d;
  logic                     we_d;
  logic                     load_d;
  logic                     branch_taken_e;
  logic [NUM_SRC*SELW-1:0]  fwd_sel_e;
  logic                     stall_f;
  logic                     stall_d;
  logic                     flush_d;
  logic                     flush_e;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]              stall_cnt;
  logic [31:0]              flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .valid_d        (valid_d),
    .ra_d           (ra_d),
    .rd_d           (rd_d),
    .we_d           (we_d),
    .load_d         (load_d),
    .branch_taken_e (branch_taken_e),
    .fwd_sel_e      (fwd_sel_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic [AW-1:0] rd, input logic we, input logic ld, input logic br);
    valid_d        = v;
    ra_d           = {ra1, ra0};
    rd_d           = rd;
    we_d           = we;
    load_d         = ld;
    branch_taken_e = br;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    set_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with active inputs: every output must read 0.
    reset = 1'b1;
    set_d(1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rst_flush_d", {31'd0, flush_d}, 32'd0);
    chk("rst_flush_e", {31'd0, flush_e}, 32'd0);
    chk("rst_stall_f", {31'd0, stall_f}, 32'd0);
    tick;
    tick;
    reset = 1'b0;
    bubble();
    #1;
    chk("empty_fwd", {28'd0, fwd_sel_e}, 32'd0);
    chk("empty_stall_d", {31'd0, stall_d}, 32'd0);

    // ADD r1 then reader of r1 on src0: forward from slot1.
    set_d(1'b1, 4'd5, 4'd6, 4'd1, 1'b1, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd1, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0);
    #1;
    chk("add_no_stall", {31'd0, stall_d}, 32'd0);
    tick;
    bubble();
    #1;
    chk("fwd_slot1", {28'd0, fwd_sel_e}, 32'h1);

    // Writer r2, unrelated, reader of r2 on both sources: both from slot2.
    set_d(1'b1, 4'd5, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd10, 4'd11, 4'd9, 1'b1, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd2, 4'd2, 4'd12, 1'b0, 1'b0, 1'b0);
    tick;
    bubble();
    #1;
    chk("fwd_both_slot2", {28'd0, fwd_sel_e}, 32'hA);

    // LDR r3 then reader: one-cycle load-use stall, then forward from slot2.
    set_d(1'b1, 4'd13, 4'd14, 4'd3, 1'b1, 1'b1, 1'b0);
    tick;
    set_d(1'b1, 4'd3, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0);
    #1;
    chk("luse_stall_f", {31'd0, stall_f}, 32'd1);
    chk("luse_stall_d", {31'd0, stall_d}, 32'd1);
    chk("luse_flush_e", {31'd0, flush_e}, 32'd1);
    chk("luse_flush_d", {31'd0, flush_d}, 32'd0);
    tick;
    chk("luse_released", {31'd0, stall_d}, 32'd0);
    chk("luse_no_flush_e", {31'd0, flush_e}, 32'd0);
    tick;
    bubble();
    #1;
    chk("ld_fwd_slot2", {28'd0, fwd_sel_e}, 32'h2);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_one", stall_cnt, 32'd1);
`endif

    // LDR r3 in E with reader in D and branch taken: branch wins.
    set_d(1'b1, 4'd13, 4'd14, 4'd3, 1'b1, 1'b1, 1'b0);
    tick;
    set_d(1'b1, 4'd3, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br_stall_d", {31'd0, stall_d}, 32'd0);
    chk("br_stall_f", {31'd0, stall_f}, 32'd0);
    chk("br_flush_d", {31'd0, flush_d}, 32'd1);
    chk("br_flush_e", {31'd0, flush_e}, 32'd1);
    tick;
    bubble();
    #1;
    chk("br_slot0_bubble", {28'd0, fwd_sel_e}, 32'd0);

    // Two writers of r4: youngest (slot1) wins.
    set_d(1'b1, 4'd5, 4'd6, 4'd4, 1'b1, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd5, 4'd6, 4'd4, 1'b1, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd4, 4'd0, 4'd11, 1'b0, 1'b0, 1'b0);
    tick;
    bubble();
    #1;
    chk("youngest_wins", {28'd0, fwd_sel_e}, 32'h1);

    // Same, but slot1 has we=0: slot2 wins.
    set_d(1'b1, 4'd5, 4'd6, 4'd4, 1'b1, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd5, 4'd6, 4'd4, 1'b0, 1'b0, 1'b0);
    tick;
    set_d(1'b1, 4'd4, 4'd0, 4'd11, 1'b0, 1'b0, 1'b0);
    tick;
    bubble();
    #1;
    chk("we0_skipped", {28'd0, fwd_sel_e}, 32'h2);

    // Reset asserted during a load-use stall.
    set_d(1'b1, 4'd13, 4'd14, 4'd3, 1'b1, 1'b1, 1'b0);
    tick;
    set_d(1'b1, 4'd3, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", {31'd0, stall_d}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall_d", {31'd0, stall_d}, 32'd0);
    chk("rst_mid_flush_e", {31'd0, flush_e}, 32'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("post_rst_stall_d", {31'd0, stall_d}, 32'd0);
    chk("post_rst_stall_f", {31'd0, stall_f}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    tick;
    bubble();
    #1;
    chk("post_rst_fwd", {28'd0, fwd_sel_e}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
